// File: rtl/bridge_pkg.sv
// Shared definitions for the GPS-sample SPI bridge: sample layout, nibble index
// width and the self-test pattern used by both the transmitter and the receiver.
package bridge_pkg;

  localparam int SAMPLE_W  = 4;
  localparam int I0        = 0;
  localparam int I1        = 1;
  localparam int Q0        = 2;
  localparam int Q1        = 3;
  localparam int NIB_IDX_W = 9;

  typedef logic [SAMPLE_W-1:0] sample_t;

  function automatic sample_t bitrev4(input sample_t v);
    sample_t r;
    r[I0] = v[Q1];
    r[I1] = v[Q0];
    r[Q0] = v[I1];
    r[Q1] = v[I0];
    return r;
  endfunction

  // Even indices carry the reversed upper index bits, odd ones the reversed lower bits.
  function automatic sample_t st_expected(input logic [NIB_IDX_W-1:0] n);
    return n[0] ? bitrev4(n[4:1]) : bitrev4(n[8:5]);
  endfunction

endpackage

// File: rtl/bridge_rx_fifo.sv
// First-word-fall-through sample FIFO with full/empty flags; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module bridge_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    // Masked while empty so the head reads zero out of reset.
    rdata    = empty ? '0 : mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/bridge_rx.sv
// Receive end of the GPS-sample SPI bridge: synchronizes SCK/SS/MOSI, rebuilds
// {Q1,Q0,I1,I0} nibbles, buffers them and checks the self-test pattern.
module bridge_rx
  import bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ERR_W      = 16
) (
  input  logic                MCU_CLK,
  input  logic                RESET_N,
  input  logic                MCU_SCK,
  input  logic                MCU_SS,
  input  logic                MCU_MOSI,
  input  logic                SELF_TEST,
  output logic [SAMPLE_W-1:0] SAMPLE,
  output logic                SAMPLE_VALID,
  input  logic                SAMPLE_READY,
  output logic                OVERFLOW,
  output logic                FRAME_ERR,
  output logic [ERR_W-1:0]    ERR_COUNT,
  input  logic                CLEAR
);

  localparam int SCK_B = 0;
  localparam int SS_B  = 1;
  localparam int MOSI_B = 2;
  // Idle levels: SCK and SS high, MOSI low, so reset never fakes an edge.
  localparam logic [2:0] SYNC_RST = 3'b011;

  logic [2:0]           sync1_q, sync1_d;
  logic [2:0]           sync2_q, sync2_d;
  logic [2:0]           hist_q, hist_d;
  logic                 rise_q, rise_d;
  logic                 ss_rise_q, ss_rise_d;
  logic [1:0]           k_q, k_d;
  sample_t              shift_q, shift_d;
  sample_t              nib_q, nib_d;
  logic                 push_q, push_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overflow_q, overflow_d;
  logic [NIB_IDX_W-1:0] n_q, n_d;
  logic [ERR_W-1:0]     err_q, err_d;

  logic                 fifo_full, fifo_empty;
  logic                 pop, drop;

  always_comb begin
    sync1_d   = {MCU_MOSI, MCU_SS, MCU_SCK};
    sync2_d   = sync1_q;
    hist_d    = sync2_q;
    rise_d    = sync2_q[SCK_B] & ~hist_q[SCK_B] & ~sync2_q[SS_B];
    ss_rise_d = sync2_q[SS_B] & ~hist_q[SS_B];
  end

  // Bit shifter; hist_q[MOSI_B] is the data sampled alongside the registered edge.
  always_comb begin
    k_d         = k_q;
    shift_d     = shift_q;
    nib_d       = nib_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    if (CLEAR) begin
      k_d     = '0;
      shift_d = '0;
    end else if (ss_rise_q) begin
      frame_err_d = (k_q != 2'd0);
      k_d         = '0;
    end else if (rise_q) begin
      shift_d[k_q] = hist_q[MOSI_B];
      if (k_q == 2'd3) begin
        push_d = 1'b1;
        nib_d  = shift_d;
        k_d    = '0;
      end else begin
        k_d = k_q + 2'd1;
      end
    end
  end

  // Push/drop decision and the pattern checker act on the same completed nibble.
  always_comb begin
    pop        = ~fifo_empty & SAMPLE_READY;
    drop       = push_q & fifo_full & ~pop;
    overflow_d = overflow_q | drop;
    n_d        = n_q;
    err_d      = err_q;
    if (push_q && SELF_TEST) begin
      n_d = n_q + NIB_IDX_W'(1);
      if ((nib_q != st_expected(n_q)) && (err_q != '1)) begin
        err_d = err_q + ERR_W'(1);
      end
    end
    if (CLEAR) begin
      overflow_d = 1'b0;
      n_d        = '0;
      err_d      = '0;
    end
  end

  always_ff @(posedge MCU_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q     <= SYNC_RST;
      sync2_q     <= SYNC_RST;
      hist_q      <= SYNC_RST;
      rise_q      <= 1'b0;
      ss_rise_q   <= 1'b0;
      k_q         <= '0;
      shift_q     <= '0;
      nib_q       <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      n_q         <= '0;
      err_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      rise_q      <= rise_d;
      ss_rise_q   <= ss_rise_d;
      k_q         <= k_d;
      shift_q     <= shift_d;
      nib_q       <= nib_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      n_q         <= n_d;
      err_q       <= err_d;
    end
  end

  bridge_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (MCU_CLK),
    .rst_n (RESET_N),
    .push  (push_q),
    .wdata (nib_q),
    .pop   (pop),
    .rdata (SAMPLE),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign SAMPLE_VALID = ~fifo_empty;
  assign OVERFLOW     = overflow_q;
  assign FRAME_ERR    = frame_err_q;
  assign ERR_COUNT    = err_q;

endmodule

// File: tb/tb_bridge_rx.sv
// Bench for bridge_rx: serial stimulus tasks, a sample scoreboard queue and
// hand-written sequences for latency, overflow, frame error, reset and self-test.
module tb_bridge_rx;

  localparam int DEPTH = 16;
  localparam int EW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sck = 1'b0;
  logic          ss = 1'b1;
  logic          mosi = 1'b0;
  logic          self_test = 1'b0;
  logic          ready = 1'b0;
  logic          clear = 1'b0;
  logic [3:0]    sample;
  logic          valid, ovf, fe;
  logic [EW-1:0] errc;

  int            checks = 0;
  int            errors = 0;
  int            fe_cnt = 0;
  logic [3:0]    sb[$];

  typedef struct {
    logic [3:0] seq;   // send order: seq[3] first
    logic [3:0] want;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  bridge_rx #(.FIFO_DEPTH(DEPTH), .ERR_W(EW)) dut (
    .MCU_CLK      (clk),
    .RESET_N      (rst_n),
    .MCU_SCK      (sck),
    .MCU_SS       (ss),
    .MCU_MOSI     (mosi),
    .SELF_TEST    (self_test),
    .SAMPLE       (sample),
    .SAMPLE_VALID (valid),
    .SAMPLE_READY (ready),
    .OVERFLOW     (ovf),
    .FRAME_ERR    (fe),
    .ERR_COUNT    (errc),
    .CLEAR        (clear)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] w;
    if (fe) fe_cnt++;
    if (rst_n && valid && ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=%0h required=none", sample);
      end else begin
        w = sb.pop_front();
        check("pop", {28'd0, sample}, {28'd0, w});
      end
    end
  end

  function automatic logic [3:0] pat(input int n);
    logic [8:0] v;
    logic [3:0] f;
    v = n[8:0];
    f = v[0] ? v[4:1] : v[8:5];
    return {f[0], f[1], f[2], f[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // pop3 raises READY during the cycle the completed nibble is being pushed.
  task automatic send_bit(input logic b, input bit pop3);
    mosi = b;
    repeat (2) tick();
    sck = 1'b1;
    repeat (4) tick();
    if (pop3) ready = 1'b1;
    tick();
    if (pop3) ready = 1'b0;
    sck = 1'b0;
    tick();
  endtask

  task automatic send_sample(input logic [3:0] s, input bit pop_last);
    for (int i = 0; i < 4; i++) send_bit(s[i], pop_last && (i == 3));
  endtask

  task automatic send_seq(input logic [3:0] seq);
    for (int i = 3; i >= 0; i--) send_bit(seq[i], 1'b0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic drain();
    int t;
    t = 0;
    ready = 1'b1;
    while (sb.size() != 0 && t < 500) begin
      tick();
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 entries left", sb.size());
      sb.delete();
    end
    repeat (2) tick();
    check("empty_after_drain", {31'd0, valid}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int fe0;
    vecs[0] = '{4'b1011, 4'b1101};
    vecs[1] = '{4'b0000, 4'b0000};
    vecs[2] = '{4'b1111, 4'b1111};
    vecs[3] = '{4'b1000, 4'b0001};
    vecs[4] = '{4'b0001, 4'b1000};
    vecs[5] = '{4'b0110, 4'b0110};
    vecs[6] = '{4'b1100, 4'b0011};
    vecs[7] = '{4'b0101, 4'b1010};

    // Reset state
    repeat (3) tick();
    check("rst_sample", {28'd0, sample}, 0);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_ovf", {31'd0, ovf}, 0);
    check("rst_fe", {31'd0, fe}, 0);
    check("rst_err", {28'd0, errc}, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_valid", {31'd0, valid}, 0);

    // Single frame 1,0,1,1 with valid latency
    fe0 = fe_cnt;
    ss = 1'b0;
    repeat (3) tick();
    sb.push_back(4'b1101);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    mosi = 1'b1;
    repeat (2) tick();
    sck = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      tick();
      if (c == 3) check("lat_valid_c3", {31'd0, valid}, 0);
      if (c == 4) check("lat_valid_c4", {31'd0, valid}, 1);
    end
    sck = 1'b0;
    tick();
    ss = 1'b1;
    repeat (6) tick();
    check("frame1_no_fe", fe_cnt - fe0, 0);
    drain();

    // Table of nibbles in one frame
    ss = 1'b0;
    repeat (3) tick();
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(vecs[i].want);
      send_seq(vecs[i].seq);
    end
    ss = 1'b1;
    repeat (6) tick();
    drain();

    // Overflow: 18 nibbles with no pops, then a push concurrent with a pop
    ready = 1'b0;
    ss = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < DEPTH + 2; i++) begin
      logic [3:0] s;
      s = 4'((i * 7 + 3) & 15);
      if (i < DEPTH) sb.push_back(s);
      send_sample(s, 1'b0);
    end
    check("ovf_set", {31'd0, ovf}, 1);
    sb.push_back(4'hE);
    send_sample(4'hE, 1'b1);
    check("ovf_sticky", {31'd0, ovf}, 1);
    check("fifo_count_full", sb.size(), DEPTH);
    ss = 1'b1;
    repeat (6) tick();
    drain();

    // Frame error after two bits, then an aligned nibble
    fe0 = fe_cnt;
    ss = 1'b0;
    repeat (3) tick();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    ss = 1'b1;
    repeat (3) tick();
    check("fe_c2", {31'd0, fe}, 0);
    tick();
    check("fe_c3", {31'd0, fe}, 1);
    tick();
    check("fe_c4", {31'd0, fe}, 0);
    repeat (4) tick();
    check("fe_once", fe_cnt - fe0, 1);
    check("fe_no_push", {31'd0, valid}, 0);
    ss = 1'b0;
    repeat (3) tick();
    sb.push_back(4'b0010);
    send_seq(4'b0100);
    ss = 1'b1;
    repeat (6) tick();
    drain();

    // Reset mid-nibble with three samples stored
    ready = 1'b0;
    ss = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      sb.push_back(4'(i + 9));
      send_sample(4'(i + 9), 1'b0);
    end
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("pre_rst_valid", {31'd0, valid}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, valid}, 0);
    check("mid_rst_sample", {28'd0, sample}, 0);
    check("mid_rst_ovf", {31'd0, ovf}, 0);
    check("mid_rst_err", {28'd0, errc}, 0);
    sb.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    fe0 = fe_cnt;
    ready = 1'b1;
    sb.push_back(4'b0110);
    send_sample(4'b0110, 1'b0);
    ss = 1'b1;
    repeat (6) tick();
    check("post_rst_no_fe", fe_cnt - fe0, 0);
    drain();

    // Self-test: 1024 pattern nibbles across three frames
    pulse_clear();
    self_test = 1'b1;
    fe0 = fe_cnt;
    ss = 1'b0;
    repeat (3) tick();
    for (int n = 0; n < 1024; n++) begin
      if (n == 400 || n == 800) begin
        ss = 1'b1;
        repeat (5) tick();
        ss = 1'b0;
        repeat (3) tick();
      end
      sb.push_back(pat(n));
      send_sample(pat(n), 1'b0);
    end
    check("st_clean_err", {28'd0, errc}, 0);
    check("st_frames_no_fe", fe_cnt - fe0, 0);
    // Index has wrapped to 0; flip a bit in nibble 37
    for (int n = 0; n < 40; n++) begin
      logic [3:0] s;
      s = (n == 37) ? (pat(n) ^ 4'b0100) : pat(n);
      sb.push_back(s);
      send_sample(s, 1'b0);
    end
    check("st_one_err", {28'd0, errc}, 1);
    self_test = 1'b0;
    sb.push_back(~pat(40));
    send_sample(~pat(40), 1'b0);
    check("st_off_hold", {28'd0, errc}, 1);
    self_test = 1'b1;
    sb.push_back(pat(40));
    send_sample(pat(40), 1'b0);
    check("st_idx_held", {28'd0, errc}, 1);
    ss = 1'b1;
    repeat (6) tick();
    drain();

    // Saturation, overflow, then CLEAR (FIFO contents survive)
    pulse_clear();
    check("clr_err0", {28'd0, errc}, 0);
    ready = 1'b0;
    ss = 1'b0;
    repeat (3) tick();
    for (int n = 0; n < DEPTH + 1; n++) begin
      if (n < DEPTH) sb.push_back(~pat(n));
      send_sample(~pat(n), 1'b0);
    end
    check("sat_err", {28'd0, errc}, 15);
    check("sat_ovf", {31'd0, ovf}, 1);
    pulse_clear();
    check("clr_err", {28'd0, errc}, 0);
    check("clr_ovf", {31'd0, ovf}, 0);
    check("clr_keeps_fifo", {31'd0, valid}, 1);
    ss = 1'b1;
    repeat (6) tick();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
